adc_window_averager: RTL and testbench

//  Downstream consumer of the SPI ADC control block. Takes each 4-channel 12-bit

---
 rtl/adc_pkg.sv | 28 ++
 rtl/adc_peak_bar.sv | 56 +++++
 rtl/adc_window_averager.sv | 118 +++++++++++
 tb/tb_adc_window_averager.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants, FSM encoding and LED bar decode helper for the ADC
// window averager.
package adc_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_NUM_CH = 4;
    localparam int LED_W      = 8;
    localparam int LVL_W      = 4;

    typedef enum logic {
        S_ACC  = 1'b0,
        S_DONE = 1'b1
    } state_e;

    // Thermometer of 'level' lit LEDs, plus a single marker LED at 'peak'
    // (peak of zero means no window has completed yet).
    function automatic logic [LED_W-1:0] bar_decode(
        input logic [LVL_W-1:0] level,
        input logic [LVL_W-1:0] peak
    );
        logic [LED_W-1:0] thermo;
        logic [LED_W-1:0] marker;
        thermo = (LED_W'(1) << level) - LED_W'(1);
        marker = (peak == '0) ? '0 : (LED_W'(1) << (peak - LVL_W'(1)));
        return thermo | marker;
    endfunction

endpackage

// File: rtl/adc_peak_bar.sv
// Bar-graph level of the channel-0 average with a decaying peak marker,
// refreshed once per completed averaging window.
module adc_peak_bar
    import adc_pkg::*;
#(
    parameter int DATA_W        = ADC_DATA_W,
    parameter int PEAK_HOLD_WIN = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] avg_i,
    input  logic              valid_i,
    output logic [LED_W-1:0]  led_bar_o
);

    localparam int HOLD_W = $clog2(PEAK_HOLD_WIN + 1);

    logic [LVL_W-1:0]  level_q, level_d;
    logic [LVL_W-1:0]  peak_q, peak_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [LVL_W-1:0]  level_new;

    assign level_new = {1'b0, avg_i[DATA_W-1 -: 3]} + LVL_W'(1);

    always_comb begin
        level_d = level_q;
        peak_d  = peak_q;
        hold_d  = hold_q;
        if (valid_i) begin
            level_d = level_new;
            if (level_new >= peak_q) begin
                peak_d = level_new;
                hold_d = HOLD_W'(PEAK_HOLD_WIN);
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end else if (peak_q > level_new) begin
                peak_d = peak_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= '0;
            peak_q  <= '0;
            hold_q  <= '0;
        end else begin
            level_q <= level_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
        end
    end

    assign led_bar_o = bar_decode(level_q, peak_q);

endmodule

// File: rtl/adc_window_averager.sv
// Averages 2**AVG_LOG2 consecutive 4-channel ADC sample sets and drives an
// LED bar with peak-hold for channel 0.
module adc_window_averager
    import adc_pkg::*;
#(
    parameter int DATA_W        = ADC_DATA_W,
    parameter int AVG_LOG2      = 3,
    parameter int PEAK_HOLD_WIN = 4
) (
    input  logic                ref_clk,
    input  logic                reset,
    input  logic                sample_ready,
    input  logic [DATA_W-1:0]   ch0_in,
    input  logic [DATA_W-1:0]   ch1_in,
    input  logic [DATA_W-1:0]   ch2_in,
    input  logic [DATA_W-1:0]   ch3_in,
    output logic [DATA_W-1:0]   avg_ch0,
    output logic [DATA_W-1:0]   avg_ch1,
    output logic [DATA_W-1:0]   avg_ch2,
    output logic [DATA_W-1:0]   avg_ch3,
    output logic                avg_valid,
    output logic [AVG_LOG2-1:0] win_count,
    output logic [LED_W-1:0]    led_bar
);

    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic                ready_q;
    logic                accept;
    state_e              state_q, state_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q [ADC_NUM_CH];
    logic [ACC_W-1:0]    acc_d [ADC_NUM_CH];
    logic [DATA_W-1:0]   avg_q [ADC_NUM_CH];
    logic [DATA_W-1:0]   avg_d [ADC_NUM_CH];
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   ch_in [ADC_NUM_CH];

    assign ch_in[0] = ch0_in;
    assign ch_in[1] = ch1_in;
    assign ch_in[2] = ch2_in;
    assign ch_in[3] = ch3_in;

    // ready_q clears on reset, so a level already high counts as a new set.
    assign accept = sample_ready & ~ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        avg_d   = avg_q;
        valid_d = 1'b0;
        unique case (state_q)
            S_ACC: begin
                if (accept) begin
                    for (int c = 0; c < ADC_NUM_CH; c++) begin
                        acc_d[c] = acc_q[c] + ACC_W'(ch_in[c]);
                    end
                    cnt_d = cnt_q + AVG_LOG2'(1);
                    if (cnt_q == '1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                for (int c = 0; c < ADC_NUM_CH; c++) begin
                    avg_d[c] = DATA_W'(acc_q[c] >> AVG_LOG2);
                    acc_d[c] = accept ? ACC_W'(ch_in[c]) : '0;
                end
                cnt_d   = accept ? AVG_LOG2'(1) : '0;
                valid_d = 1'b1;
                state_d = S_ACC;
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            state_q <= S_ACC;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            for (int c = 0; c < ADC_NUM_CH; c++) begin
                acc_q[c] <= '0;
                avg_q[c] <= '0;
            end
        end else begin
            ready_q <= sample_ready;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            for (int c = 0; c < ADC_NUM_CH; c++) begin
                acc_q[c] <= acc_d[c];
                avg_q[c] <= avg_d[c];
            end
        end
    end

    assign avg_ch0   = avg_q[0];
    assign avg_ch1   = avg_q[1];
    assign avg_ch2   = avg_q[2];
    assign avg_ch3   = avg_q[3];
    assign avg_valid = valid_q;
    assign win_count = cnt_q;

    adc_peak_bar #(
        .DATA_W        (DATA_W),
        .PEAK_HOLD_WIN (PEAK_HOLD_WIN)
    ) u_peak_bar (
        .clk_i     (ref_clk),
        .rst_i     (reset),
        .avg_i     (avg_q[0]),
        .valid_i   (valid_q),
        .led_bar_o (led_bar)
    );

endmodule

// File: tb/tb_adc_window_averager.sv
// Scoreboard bench: window averages and LED bar predicted from plain
// arithmetic over the accepted sample sets.
module tb_adc_window_averager;

    localparam int N    = 8;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_ready = 1'b0;
    logic [11:0] ch0_in = '0, ch1_in = '0, ch2_in = '0, ch3_in = '0;
    logic [11:0] avg_ch0, avg_ch1, avg_ch2, avg_ch3;
    logic        avg_valid;
    logic [2:0]  win_count;
    logic [7:0]  led_bar;

    adc_window_averager dut (
        .ref_clk      (clk),
        .reset        (reset),
        .sample_ready (sample_ready),
        .ch0_in       (ch0_in),
        .ch1_in       (ch1_in),
        .ch2_in       (ch2_in),
        .ch3_in       (ch3_in),
        .avg_ch0      (avg_ch0),
        .avg_ch1      (avg_ch1),
        .avg_ch2      (avg_ch2),
        .avg_ch3      (avg_ch3),
        .avg_valid    (avg_valid),
        .win_count    (win_count),
        .led_bar      (led_bar)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a0;
        int a1;
        int a2;
        int a3;
        int led;
        int due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   sums[4];
    int   n = 0;
    int   pk = 0;
    int   hd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at cyc %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        n = 0;
        for (int c = 0; c < 4; c++) sums[c] = 0;
        pk = 0;
        hd = 0;
        sb.delete();
    endtask

    // Called at the negedge right after the accepting clock edge.
    task automatic model_accept(input int c0, input int c1,
                                input int c2, input int c3);
        exp_t e;
        int   lvl;
        sums[0] += c0; sums[1] += c1; sums[2] += c2; sums[3] += c3;
        n++;
        if (n == N) begin
            e.a0 = sums[0] / N;
            e.a1 = sums[1] / N;
            e.a2 = sums[2] / N;
            e.a3 = sums[3] / N;
            lvl = e.a0 / 512 + 1;
            if (lvl >= pk) begin
                pk = lvl;
                hd = HOLD;
            end else if (hd > 0) begin
                hd--;
            end else if (pk > lvl) begin
                pk--;
            end
            e.led = ((1 << lvl) - 1) | (1 << (pk - 1));
            e.due = cyc + 1;
            sb.push_back(e);
            n = 0;
            for (int c = 0; c < 4; c++) sums[c] = 0;
        end
    endtask

    task automatic issue(input int c0, input int c1, input int c2,
                         input int c3, input int hi, input int gap);
        @(negedge clk);
        ch0_in = 12'(c0);
        ch1_in = 12'(c1);
        ch2_in = 12'(c2);
        ch3_in = 12'(c3);
        sample_ready = 1'b1;
        for (int i = 0; i < hi; i++) begin
            @(negedge clk);
            if (i == 0) model_accept(c0, c1, c2, c3);
            chk("win_count", int'(win_count), n);
        end
        sample_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic rand_set();
        issue($urandom_range(0, 4095), $urandom_range(0, 4095),
              $urandom_range(0, 4095), $urandom_range(0, 4095),
              $urandom_range(1, 3), $urandom_range(0, 3));
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_avg0"}, int'(avg_ch0), 0);
        chk({nm, "_avg1"}, int'(avg_ch1), 0);
        chk({nm, "_avg2"}, int'(avg_ch2), 0);
        chk({nm, "_avg3"}, int'(avg_ch3), 0);
        chk({nm, "_valid"}, int'(avg_valid), 0);
        chk({nm, "_wc"}, int'(win_count), 0);
        chk({nm, "_led"}, int'(led_bar), 0);
    endtask

    logic led_pend = 1'b0;
    logic prev_v = 1'b0;
    int   led_exp = 0;

    always @(negedge clk) begin
        if (reset) begin
            led_pend = 1'b0;
            prev_v   = 1'b0;
        end else begin
            if (led_pend) begin
                chk("led_bar", int'(led_bar), led_exp);
                led_pend = 1'b0;
            end
            if (avg_valid) begin
                if (prev_v) chk("valid_width", 2, 1);
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("avg_ch0", int'(avg_ch0), e.a0);
                    chk("avg_ch1", int'(avg_ch1), e.a1);
                    chk("avg_ch2", int'(avg_ch2), e.a2);
                    chk("avg_ch3", int'(avg_ch3), e.a3);
                    chk("valid_latency", cyc, e.due);
                    led_exp  = e.led;
                    led_pend = 1'b1;
                end
            end
            prev_v = avg_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: mid-scale on all channels
        for (int i = 0; i < N; i++) issue(12'h800, 12'h800, 12'h800, 12'h800, 1, 0);
        repeat (4) @(negedge clk);

        // 2: ramp on ch0, truncating average
        for (int i = 0; i < N; i++)
            issue(100 + i, $urandom_range(0, 4095), i * 500, 4095 - i, 1, 1);
        repeat (4) @(negedge clk);

        // 3: level held high is a single set
        issue(12'h123, 12'h456, 12'h789, 12'hABC, 20, 2);
        for (int i = 1; i < N; i++) rand_set();

        // 4: back-to-back sets straddling window boundaries
        for (int i = 0; i < 2 * N + 3; i++)
            issue($urandom_range(0, 4095), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), $urandom_range(0, 4095), 1, 0);
        for (int i = 3; i < N; i++) rand_set();

        for (int w = 0; w < 20 * N; w++) rand_set();
        repeat (6) @(negedge clk);

        // 5: reset mid-window, then re-arm with ready already high
        for (int i = 0; i < 5; i++) rand_set();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        sample_ready = 1'b1;
        ch0_in = 12'hFFF; ch1_in = 12'hFFF; ch2_in = 12'hFFF; ch3_in = 12'hFFF;
        model_reset();
        @(negedge clk);
        check_zero("midreset");
        reset = 1'b0;
        @(negedge clk);
        model_accept(4095, 4095, 4095, 4095);
        chk("rearm_wc", int'(win_count), 1);
        sample_ready = 1'b0;
        for (int i = 1; i < N; i++) issue(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1, 0);
        repeat (4) @(negedge clk);

        // 6: zero windows let the peak marker hold then decay
        for (int w = 0; w < 12 * N; w++) issue(0, 0, 0, 0, 1, 0);
        repeat (10) @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
